// File: rtl/duc_nco_pkg.sv
`default_nettype none
//==============================================================================
// Module   : duc_nco_pkg
// Brief    : Shared helpers for the BPSK up-converter: LUT amplitude, LUT
//            sample generation and the round/saturate output function.
// Revision : 1.0 - initial release
//==============================================================================
package duc_nco_pkg;

  // Working width of the generic rounding/saturation arithmetic
  localparam int unsigned SAT_W = 64;

  // Peak LUT magnitude 2^(cwidth-1)-1 (symmetric, never hits the negative rail)
  function automatic longint lut_amp(input int unsigned cwidth);
    return longint'((64'sd1 <<< (cwidth - 1)) - 64'sd1);
  endfunction

  // One carrier sample, rounded half away from zero; evaluated at elaboration
  function automatic longint lut_value(input int unsigned k,
                                       input int unsigned aw,
                                       input int unsigned cwidth);
    real amp;
    real ang;
    real r;
    amp = real'(lut_amp(cwidth));
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** aw);
    r   = amp * $sin(ang);
    if (r >= 0.0) begin
      return longint'($rtoi(r + 0.5));
    end
    return -longint'($rtoi(-r + 0.5));
  endfunction

  // Round-half-up by 'shift' bits, then clamp to a signed 'owidth' range.
  // The operand's low 'in_w' bits are taken as a signed value, so callers may
  // pass a zero-padded product of any width up to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] x,
                                                         input int unsigned in_w,
                                                         input int unsigned owidth,
                                                         input int unsigned shift);
    logic signed [SAT_W-1:0] xe;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    xe = (x <<< (SAT_W - in_w)) >>> (SAT_W - in_w);
    r  = xe;
    if (shift > 0) begin
      r = (xe + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (owidth - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (owidth - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/duc_sin_lut.sv
`default_nettype none
//==============================================================================
// Module   : duc_sin_lut
// Brief    : 2^LUT_AW x CWIDTH synchronous sine ROM, contents computed at
//            elaboration time.
// Revision : 1.0 - initial release
//==============================================================================
module duc_sin_lut
  import duc_nco_pkg::*;
#(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned CWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [CWIDTH-1:0] data
);

  localparam int unsigned C_DEPTH = 1 << LUT_AW;

  logic signed [CWIDTH-1:0] rom_w [C_DEPTH];
  logic signed [CWIDTH-1:0] data_d;
  logic signed [CWIDTH-1:0] data_q;

  for (genvar k = 0; k < C_DEPTH; k++) begin : g_rom
    localparam logic signed [CWIDTH-1:0] C_VAL = CWIDTH'(lut_value(k, LUT_AW, CWIDTH));
    assign rom_w[k] = C_VAL;
  end

  // ROM read
  always_comb begin
    data_d = rom_w[addr];
  end

  // Registered ROM output (one cycle read latency)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/duc_nco.sv
`default_nettype none
//==============================================================================
// Module   : duc_nco
// Brief    : BPSK digital up-converter. Holds each symbol for SPS samples and
//            multiplies it by an NCO sine carrier, then rounds/saturates.
//            Pipeline: E0 hold/addr, E1 ROM, E2 product, E3 output.
// Revision : 1.0 - initial release
//==============================================================================
module duc_nco
  import duc_nco_pkg::*;
#(
  parameter int unsigned BWIDTH = 2,
  parameter int unsigned CWIDTH = 16,
  parameter int unsigned OWIDTH = 16,
  parameter int unsigned PWIDTH = 32,
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned SPS    = 8,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [PWIDTH-1:0]        phase_inc,
  input  logic signed [BWIDTH-1:0] sym_data,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic signed [OWIDTH-1:0] duc_sig,
  output logic                     duc_valid,
  output logic                     underrun
);

  localparam int unsigned C_PRODW    = BWIDTH + CWIDTH;
  localparam int unsigned C_CNTW     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [C_CNTW-1:0] C_CNT_LAST = C_CNTW'(SPS - 1);

  // Stage E0 state: symbol counter, phase accumulator, hold register, address
  logic [C_CNTW-1:0]        cnt_q, cnt_d;
  logic [PWIDTH-1:0]        phase_q, phase_d;
  logic signed [BWIDTH-1:0] hold_q, hold_d;
  logic [LUT_AW-1:0]        addr_q, addr_d;
  logic                     v0_q, v0_d;
  logic                     underrun_q, underrun_d;
  // Stages E1..E3
  logic signed [BWIDTH-1:0] sym1_q, sym1_d;
  logic                     v1_q, v1_d;
  logic signed [C_PRODW-1:0] prod_q, prod_d;
  logic                     v2_q, v2_d;
  logic signed [OWIDTH-1:0] sig_q, sig_d;
  logic                     valid_q, valid_d;

  logic signed [CWIDTH-1:0] lut_w;
  logic                     cnt_zero_w;

  assign cnt_zero_w = (cnt_q == '0);
  assign sym_ready  = en & cnt_zero_w & rst_n;

  duc_sin_lut #(
    .LUT_AW (LUT_AW),
    .CWIDTH (CWIDTH)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_q),
    .data  (lut_w)
  );

  // Symbol slot counter, handshake/underrun and NCO advance; all frozen when en=0
  always_comb begin
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    underrun_d = 1'b0;
    v0_d       = en;
    if (en) begin
      cnt_d   = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + 1'b1;
      phase_d = phase_q + phase_inc;
      // Address comes from the pre-update phase so the first sample uses phase 0
      addr_d  = phase_q[PWIDTH-1 -: LUT_AW];
      if (cnt_zero_w) begin
        // A missing symbol becomes a zero symbol for its whole slot
        hold_d     = sym_valid ? sym_data : '0;
        underrun_d = ~sym_valid;
      end
    end
  end

  // Datapath: align symbol with ROM output, multiply, round and saturate
  always_comb begin
    logic signed [C_PRODW-1:0] sym_ext;
    logic signed [C_PRODW-1:0] lut_ext;
    logic [SAT_W-1:0]          prod_pad;
    sym1_d   = hold_q;
    v1_d     = v0_q;
    sym_ext  = {{CWIDTH{sym1_q[BWIDTH-1]}}, sym1_q};
    lut_ext  = {{BWIDTH{lut_w[CWIDTH-1]}}, lut_w};
    prod_d   = sym_ext * lut_ext;
    v2_d     = v1_q;
    prod_pad = '0;
    prod_pad[C_PRODW-1:0] = prod_q;
    sig_d    = OWIDTH'(sat_round(prod_pad, C_PRODW, OWIDTH, SHIFT));
    valid_d  = v2_q;
  end

  // E0 registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      hold_q     <= '0;
      addr_q     <= '0;
      v0_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      v0_q       <= v0_d;
      underrun_q <= underrun_d;
    end
  end

  // E1..E3 pipeline registers; these drain regardless of en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym1_q  <= '0;
      v1_q    <= 1'b0;
      prod_q  <= '0;
      v2_q    <= 1'b0;
      sig_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sym1_q  <= sym1_d;
      v1_q    <= v1_d;
      prod_q  <= prod_d;
      v2_q    <= v2_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
    end
  end

  assign duc_sig   = sig_q;
  assign duc_valid = valid_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_duc_nco.sv
`default_nettype none
//==============================================================================
// Module   : tb_duc_nco
// Brief    : Self-checking bench for duc_nco (default parameters) with a
//            sample-level reference model and the rounding helper table.
// Revision : 1.0 - initial release
//==============================================================================
module tb_duc_nco;
  import duc_nco_pkg::*;

  localparam int SPS = 8;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [31:0]        phase_inc;
  logic signed [1:0]  sym_data;
  logic               sym_valid;
  logic               sym_ready;
  logic signed [15:0] duc_sig;
  logic               duc_valid;
  logic               underrun;

  duc_nco dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase_inc (phase_inc),
    .sym_data  (sym_data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .duc_sig   (duc_sig),
    .duc_valid (duc_valid),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample stream + 3-sample delay) -------
  typedef struct { bit v; int s; } smp_t;
  smp_t        m_pipe[$];
  int          m_cnt;
  int          m_sym;
  logic [31:0] m_phase;
  bit          m_out_v;
  int          m_out_s;
  bit          m_sig_chk;
  bit          m_unr;

  function automatic int lut_ref(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int clamp16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_edge();
    smp_t nw;
    smp_t fr;
    if (!rst_n) begin
      m_cnt = 0; m_sym = 0; m_phase = '0; m_unr = 0;
      m_pipe = {};
      nw.v = 0; nw.s = 0;
      repeat (3) m_pipe.push_back(nw);
      m_out_v = 0; m_out_s = 0; m_sig_chk = 1;
    end else begin
      nw.v = en; nw.s = 0; m_unr = 0;
      if (en) begin
        if (m_cnt == 0) begin
          m_sym = sym_valid ? int'(sym_data) : 0;
          m_unr = !sym_valid;
        end
        nw.s    = clamp16(m_sym * lut_ref(int'(m_phase[31:24])));
        m_phase = m_phase + phase_inc;
        m_cnt   = (m_cnt + 1) % SPS;
      end
      m_pipe.push_back(nw);
      fr = m_pipe.pop_front();
      m_out_v = fr.v; m_out_s = fr.s; m_sig_chk = fr.v;
    end
  endtask

  logic signed [15:0] got[$];

  // One clock: drive at negedge, check ready, clock, check registered outputs
  task automatic cyc(input bit e, input bit r, input bit sv, input logic signed [1:0] sd);
    en = e; rst_n = r; sym_valid = sv; sym_data = sd;
    #1;
    chk("sym_ready", longint'(sym_ready), longint'(e && r && m_cnt == 0));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("duc_valid", longint'(duc_valid), longint'(m_out_v));
    chk("underrun", longint'(underrun), longint'(m_unr));
    if (m_sig_chk) chk("duc_sig", longint'(duc_sig), longint'(m_out_s));
    if (duc_valid) got.push_back(duc_sig);
  endtask

  // ---------------- rounding/saturation vectors -----------------------------
  typedef struct { longint x; int sh; longint exp; } sat_vec_t;
  sat_vec_t sat_tab[10];

  int carrier_exp[4];
  int neg2_exp[4];

  initial begin
    int first_v;
    int k;
    logic signed [63:0] sres;

    sat_tab[0] = '{0,      0, 0};
    sat_tab[1] = '{32767,  0, 32767};
    sat_tab[2] = '{32768,  0, 32767};
    sat_tab[3] = '{-32768, 0, -32768};
    sat_tab[4] = '{-65534, 0, -32768};
    sat_tab[5] = '{65536,  1, 32767};
    sat_tab[6] = '{3,      1, 2};
    sat_tab[7] = '{-3,     1, -1};
    sat_tab[8] = '{5,      2, 1};
    sat_tab[9] = '{6,      2, 2};
    carrier_exp = '{0, 32767, 0, -32767};
    neg2_exp    = '{0, -32768, 0, 32767};

    for (int i = 0; i < 10; i++) begin
      sres = sat_round(sat_tab[i].x, 18, 16, sat_tab[i].sh);
      chk($sformatf("sat_round[%0d]", i), longint'(sres), sat_tab[i].exp);
    end

    // Reset state
    phase_inc = 32'h4000_0000;
    en = 0; rst_n = 0; sym_valid = 0; sym_data = 0;
    @(negedge clk);
    repeat (3) cyc(0, 0, 0, 0);
    chk("reset duc_sig", longint'(duc_sig), 0);

    // Quarter-rate carrier with continuous +1 symbols
    got = {};
    first_v = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1, 2'sb01);
      if (first_v < 0 && duc_valid) first_v = i;
    end
    chk("valid latency", first_v, 3);
    for (int i = 0; i < 8; i++) chk("carrier seq", longint'(got[i]), carrier_exp[i % 4]);

    // Symbol -2 exercises saturation on both rails
    cyc(0, 0, 0, 0);
    got = {};
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 2'sb10);
    for (int i = 0; i < 8; i++) chk("neg2 sat seq", longint'(got[i]), neg2_exp[i % 4]);

    // Alternating +1/-1 symbols, non-trivial phase increment
    phase_inc = 32'h0321_5A7B;
    k = 0;
    for (int i = 0; i < 48; i++) begin
      cyc(1, 1, 1, (k % 2) ? 2'sb11 : 2'sb01);
      if (m_cnt == 1) k++;
    end

    // Underrun at a slot boundary, then resume
    while (m_cnt != 0) cyc(1, 1, 1, 2'sb01);
    cyc(1, 1, 0, 2'sb01);
    chk("underrun pulse", longint'(underrun), 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 2'sb11);

    // en gap mid-symbol: 1,0,0,1
    while (m_cnt != 3) cyc(1, 1, 1, 2'sb01);
    cyc(1, 1, 1, 2'sb01);
    cyc(0, 1, 1, 2'sb01);
    cyc(0, 1, 1, 2'sb01);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 2'sb01);

    // Reset pulse mid-symbol
    while (m_cnt != 5) cyc(1, 1, 1, 2'sb11);
    cyc(1, 0, 1, 2'sb11);
    chk("mid reset valid", longint'(duc_valid), 0);
    chk("mid reset sig", longint'(duc_sig), 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 2'sb01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) phase_inc = $urandom;
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 199) != 0,
          $urandom_range(0, 9) != 0, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
